// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC and issues one fetch at a time over a
// valid/ready request and valid-only response channel. It holds each fetched
// word for the IDU until consumed, and applies EXU redirects. An access fault
// parks the unit in a sticky error state until reset.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  // Set when the outstanding request was overtaken by a redirect; its reply
  // must be discarded rather than presented to the IDU.
  logic        stale_q, stale_d;
  logic [31:0] jump_target_s;

  // Redirect targets are forced to word alignment.
  assign jump_target_s = jump_addr & 32'hFFFF_FFFC;

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst_o         = inst_q;
  assign inst_addr      = inst_addr_q;
  assign fetch_err      = (state_q == S_ERR);

  // Next-state and next-register computation for the fetch sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    stale_d     = stale_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (jump_flag) begin
          pc_d = jump_target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_REQ: begin
        // The address already on the bus is accepted even when a redirect
        // lands in the same cycle; stale marks its reply for dropping.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          stale_d = jump_flag;
        end else begin
          state_d = S_REQ;
        end
        if (jump_flag) begin
          pc_d = jump_target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (jump_flag) begin
          pc_d = jump_target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rsp_valid && imem_rsp_err) begin
          state_d = S_ERR;
        end else if (imem_rsp_valid && (stale_q || jump_flag)) begin
          stale_d = 1'b0;
          state_d = S_REQ;
        end else if (imem_rsp_valid) begin
          inst_d      = imem_rsp_data;
          inst_addr_d = pc_q;
          state_d     = S_HOLD;
        end else if (jump_flag) begin
          stale_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // A redirect discards the held instruction even if the IDU is ready.
        if (jump_flag) begin
          pc_d    = jump_target_s;
          inst_d  = NOP_INST;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = RESET_PC;
        stale_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      stale_q     <= 1'b0;
      inst_q      <= NOP_INST;
      inst_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stale_q     <= stale_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Testbench for ysyx_23060332_ifu: directed scenarios followed by a randomized
// run checked against a transaction-level model of fetch order and redirects.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  ysyx_23060332_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_addr      (inst_addr),
    .jump_flag      (jump_flag),
    .jump_addr      (jump_addr),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Inputs change at negedge; outputs are sampled at negedge too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory contents used by the random run: distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  // Random-run model state
  logic [31:0] exp_next;
  int          epoch;
  logic        mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;
  int          mem_epoch;
  logic        last_good;
  logic [31:0] last_addr;
  int          delivered;
  logic        acc;

  initial begin
    @(negedge clk);
    // ---------- Test 1: reset and first fetch ----------
    rst = 1'b1;
    tick();
    tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst_inst_o", inst_o, NOP_INST);
    check("rst_inst_addr", inst_addr, RESET_PC);
    rst = 1'b0;
    tick();
    check("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t1_req_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("t1_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0;
    check("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("t1_inst_o", inst_o, 32'h0010_0093);
    check("t1_inst_addr", inst_addr, 32'h8000_0000);

    // ---------- Test 2: IDU stall ----------
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", {31'd0, inst_valid}, 32'd1);
      check("t2_stall_inst", inst_o, 32'h0010_0093);
      check("t2_stall_addr", inst_addr, 32'h8000_0000);
      check("t2_stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t2_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t2_next_req_addr", imem_req_addr, 32'h8000_0004);
    check("t2_inst_valid_low", {31'd0, inst_valid}, 32'd0);

    // ---------- Test 3: redirect while waiting ----------
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    jump_flag = 1'b1;
    jump_addr = 32'h8000_0100;
    tick();
    jump_flag = 1'b0;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("t3_dropped_valid", {31'd0, inst_valid}, 32'd0);
    check("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t3_req_addr", imem_req_addr, 32'h8000_0100);

    // ---------- Test 4: redirect beats inst_ready in HOLD ----------
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    check("t4_hold_inst", inst_o, 32'h1234_5678);
    check("t4_hold_addr", inst_addr, 32'h8000_0100);
    jump_flag  = 1'b1;
    jump_addr  = 32'h8000_0203;
    inst_ready = 1'b1;
    tick();
    jump_flag  = 1'b0;
    inst_ready = 1'b0;
    check("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h8000_0200);
    check("t4_inst_valid_low", {31'd0, inst_valid}, 32'd0);
    check("t4_inst_nop", inst_o, NOP_INST);

    // ---------- Test 5: access fault is sticky ----------
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_fetch_err", {31'd0, fetch_err}, 32'd1);
      check("t5_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("t5_no_inst", {31'd0, inst_valid}, 32'd0);
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      inst_ready     = 1'b1;
      jump_flag      = i[0];
      jump_addr      = 32'h0000_1000;
      tick();
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    jump_flag      = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_err_cleared", {31'd0, fetch_err}, 32'd0);
    check("t5_rst_inst_o", inst_o, NOP_INST);

    // ---------- Test 6: reset mid-WAIT, then PC wrap ----------
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    check("t6_no_inst", {31'd0, inst_valid}, 32'd0);
    check("t6_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t6_req_addr", imem_req_addr, 32'h8000_0000);
    jump_flag = 1'b1;
    jump_addr = 32'hFFFF_FFFE;
    tick();
    jump_flag = 1'b0;
    check("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    check("t6_top_inst_addr", inst_addr, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t6_wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t6_wrap_req_addr", imem_req_addr, 32'h0000_0000);

    // ---------- Randomized run against fetch-order model ----------
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_next  = RESET_PC;
    epoch     = 0;
    mem_busy  = 1'b0;
    mem_delay = 0;
    mem_addr  = 32'h0;
    mem_epoch = 0;
    last_good = 1'b0;
    last_addr = 32'h0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      // Observed outputs against model
      check("r_inst_valid", {31'd0, inst_valid}, {31'd0, last_good});
      if (inst_valid) begin
        check("r_inst_o", inst_o, mem_word(last_addr));
        check("r_inst_addr", inst_addr, last_addr);
      end
      if (mem_busy) begin
        check("r_one_outstanding", {31'd0, imem_req_valid}, 32'd0);
      end
      check("r_no_fault", {31'd0, fetch_err}, 32'd0);

      // Choose inputs for the coming edge
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      jump_flag      = ($urandom_range(0, 15) == 0);
      jump_addr      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      imem_rsp_valid = mem_busy && (mem_delay == 0);
      imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
      imem_rsp_err   = 1'b0;

      // Model update for this edge
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
        check("r_req_addr", imem_req_addr, exp_next);
        mem_busy  = 1'b1;
        mem_addr  = imem_req_addr;
        mem_epoch = epoch;
        mem_delay = $urandom_range(0, 3);
      end else if (mem_busy && mem_delay > 0) begin
        mem_delay = mem_delay - 1;
      end
      if (inst_valid && inst_ready && !jump_flag) begin
        exp_next  = last_addr + 32'd4;
        last_good = 1'b0;
        delivered++;
      end
      if (jump_flag) begin
        exp_next  = jump_addr & 32'hFFFF_FFFC;
        epoch++;
        last_good = 1'b0;
      end
      if (imem_rsp_valid) begin
        mem_busy = 1'b0;
        if (mem_epoch == epoch) begin
          last_good = 1'b1;
          last_addr = mem_addr;
        end
      end
      tick();
    end
    check("r_progress", {31'd0, delivered > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
